bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//  Multi-cycle adder built around one 1-bit full-adder cell (sum = a^b^c, cout = ab|bc|ac).
//  A carry flip-flop lets the cell add two WIDTH-bit operands LSB-first, one bit per clock.
//  The block sits between an operand source (start/a/b/cin) and a result consumer (done/sum/cout).
//  It trades WIDTH cycles of latency for a single adder cell.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//  clk    in   1      single clock; all state changes on the rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request: load a/b/cin and begin an add; sampled only when busy=0
//  a      in   WIDTH  operand A, captured on the accepted start edge
//  b      in   WIDTH  operand B, captured on the accepted start edge
//  cin    in   1      carry-in, captured on the accepted start edge
//  busy   out  1      1 while an add is in progress
//  done   out  1      single-cycle pulse: sum/cout were updated on this cycle's starting edge
//  sum    out  WIDTH  result, held stable from done until the next completion
//  cout   out  1      final carry-out, held with sum
// BEHAVIOUR
//  Reset: rst_n=0 forces busy=0, done=0, sum=0, cout=0 immediately (asynchronous).
//   Also clears the state (IDLE), the bit counter, the carry FF and the operand/result shift registers.
//   A reset mid-add aborts it. No done pulse is produced and sum/cout read 0.
//  States:
//   IDLE: busy=0.
//    start=1 at edge k: load sa<=a, sb<=b, carry<=cin, cnt<=0, go RUN; busy=1 from edge k.
//   RUN: each edge computes s = sa[0]^sb[0]^carry and carry <= maj(sa[0],sb[0],carry).
//    Shift sa and sb right by 1. Shift s into the MSB of the result shift register (sr).
//    Then cnt <= cnt+1.
//    The edge that processes bit WIDTH-1 (cnt==WIDTH-1) also does the following:
//     sum <= final sr contents, including this bit.
//     cout <= the new carry.
//     done <= 1, busy <= 0, state <= IDLE.
//  Latency: accepted start at edge k -> bits processed at edges k+1..k+WIDTH.
//   done=1 and the new sum/cout are visible after edge k+WIDTH, for exactly one cycle.
//   Throughput: one add per WIDTH+1 cycles.
//  Handshake rules:
//   start while busy=1 is ignored: no effect, no queuing, operands not re-sampled.
//   start=1 in the done cycle (busy=0) is accepted. The new add begins with no idle gap.
//    done still drops after one cycle, and sum/cout keep the old result until the new add completes.
//   Holding start=1 continuously gives back-to-back adds. done pulses every WIDTH+1 cycles.
//   a/b/cin may change freely after the load edge. Only the captured values are used.
//  Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). Unsigned, no overflow flag.
//   Max case: a=b=all-ones, cin=1 -> sum=all-ones, cout=1.
//  Counter: cnt is $clog2(WIDTH) bits and never wraps past WIDTH-1. The exit is decoded at WIDTH-1.
//  Outputs are registered. No combinational path from any input to any output.
// TESTING (WIDTH=8 unless stated)
//  1 Reset/idle: hold rst_n=0 -> busy=0, done=0, sum=8'h00, cout=0.
//    Release with start=0 for 20 cycles -> outputs unchanged, no done.
//  2 Latency: start pulse at edge k with a=8'h35, b=8'h4A, cin=0.
//    -> busy=1 at k..k+7, done=1 only after edge k+8, sum=8'h7F, cout=0.
//  3 Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//    Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  4 Busy protection: start a=8'h10, b=8'h20. Pulse start with a=8'hAA at cycle 3 of RUN.
//    -> result sum=8'h30 and exactly one done. Back-to-back: start held high
//    -> done every 9 cycles, and each sum matches its captured operands.
//  5 Reset mid-add: assert rst_n=0 at cycle 4 of RUN -> busy/done/sum/cout go to 0 immediately.
//    After release, no done appears. A fresh add of 8'h01+8'h01 -> sum=8'h02.
//  6 Random: 1000 random a/b/cin with random start gaps, checked against a+b+cin.
//    Repeat with WIDTH=2 and WIDTH=16.

Source files
------------

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder built from one full-adder cell and a carry flip-flop.
// One operand bit is processed per clock; the result and carry-out are registered on completion.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb, sr, sr_next;
    logic             carry, s, carry_next, last;
    always_comb begin
        s          = sa[0] ^ sb[0] ^ carry;
        carry_next = (sa[0] & sb[0]) | (sb[0] & carry) | (sa[0] & carry);
        sr_next    = {s, sr[WIDTH-1:1]};
        last       = cnt == CW'(WIDTH - 1);
    end
    assign busy = state == RUN;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sa    <= a;
                    sb    <= b;
                    carry <= cin;
                    cnt   <= '0;
                    state <= RUN;
                end
            end else begin
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                sr    <= sr_next;
                carry <= carry_next;
                cnt   <= last ? '0 : cnt + CW'(1);
                // the final bit's sum lands in sum directly, alongside the new carry
                if (last) begin
                    sum   <= sr_next;
                    cout  <= carry_next;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: scoreboard bench for bit_serial_adder at WIDTH 8 (directed + random)
// with concurrent random runs at WIDTH 2 and 16.
module tb_bit_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n, rst_g, start, cin, busy, done, cout;
    logic [7:0] a, b, sum;
    int         n_chk = 0, n_fail = 0, ndone = 0, cyc = 0, last_done = 0, n0, t;
    bit         gapchk = 1'b0;
    logic [8:0] q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon8
        logic [8:0] e;
        if (!rst_n) q8.delete();
        else begin
            if (done) begin
                ndone++;
                if (q8.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = q8.pop_front();
                    chk("sum8", {cout, sum}, e);
                end
                if (gapchk) chk("b2b_gap", cyc - last_done, 9);
                last_done = cyc;
            end
            if (start && !busy) q8.push_back({1'b0, a} + b + cin);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : gw
        localparam int W = g ? 16 : 2;
        logic         st, ci, bz, dn, co;
        logic [W-1:0] x, y, s;
        logic [W:0]   q[$];
        logic [W:0]   e;
        bit           fin = 1'b0;
        bit_serial_adder #(.WIDTH(W)) u (
            .clk(clk), .rst_n(rst_g), .start(st), .a(x), .b(y), .cin(ci),
            .busy(bz), .done(dn), .sum(s), .cout(co)
        );
        initial begin
            st = 1'b0; x = '0; y = '0; ci = 1'b0;
            @(posedge rst_g);
            repeat (2) @(posedge clk);
            #1;
            for (int i = 0; i < 1000; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                for (int k = 0; bz && k < 100; k++) begin
                    @(posedge clk);
                    #1;
                end
                x = W'($urandom); y = W'($urandom); ci = 1'($urandom); st = 1'b1;
                @(posedge clk);
                #1;
                st = 1'b0; x = W'($urandom); y = W'($urandom);
            end
            repeat (W + 4) @(posedge clk);
            chk(g ? "q16_empty" : "q2_empty", q.size(), 0);
            fin = 1'b1;
        end
        always @(negedge clk) begin
            if (rst_g) begin
                if (dn) begin
                    if (q.size() == 0) chk(g ? "spurious16" : "spurious2", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk(g ? "sum16" : "sum2", {co, s}, e);
                    end
                end
                if (st && !bz) q.push_back({1'b0, x} + y + ci);
            end
        end
    end

    task automatic go(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
        @(posedge clk);
        #1;
        a = aa; b = bb; cin = cc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 40);
        chk("done_seen", done, 1);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_g = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; rst_g = 1'b1;
        n0 = ndone;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_outs", {busy, done, cout, sum}, 0);
        chk("idle_nodone", ndone - n0, 0);

        go(8'h35, 8'h4A, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("lat_busy", busy, 1);
            chk("lat_done_lo", done, 0);
            @(posedge clk);
            #1;
        end
        chk("lat_done_hi", done, 1);
        chk("lat_busy_lo", busy, 0);
        chk("lat_sum", sum, 8'h7F);
        chk("lat_cout", cout, 0);
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);

        go(8'hFF, 8'h01, 1'b0);
        wait_done();
        chk("ripple_sum", sum, 8'h00);
        chk("ripple_cout", cout, 1);
        go(8'hFF, 8'hFF, 1'b1);
        wait_done();
        chk("max_sum", sum, 8'hFF);
        chk("max_cout", cout, 1);

        n0 = ndone;
        go(8'h10, 8'h20, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a = 8'hAA; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        chk("busy_ign_sum", sum, 8'h30);
        repeat (12) @(posedge clk);
        #1;
        chk("busy_ign_cnt", ndone - n0, 1);

        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); start = 1'b1;
        wait_done();
        gapchk = 1'b1;
        n0 = ndone;
        repeat (36) begin
            @(posedge clk);
            #1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        gapchk = 1'b0;
        chk("b2b_count", ndone - n0, 4);
        chk("b2b_q", q8.size(), 0);

        go(8'h5A, 8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, done, cout, sum}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = ndone;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_nodone", ndone - n0, 0);
        go(8'h01, 8'h01, 1'b0);
        wait_done();
        chk("post_rst_sum", sum, 8'h02);
        chk("post_rst_cout", cout, 0);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            go(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done();
        end
        chk("q8_empty", q8.size(), 0);

        t = 0;
        while (!(gw[0].fin && gw[1].fin) && t < 40000) begin
            @(posedge clk);
            t++;
        end
        chk("gen_finished", {gw[1].fin, gw[0].fin}, 2'b11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
